// File: rtl/adc_mc_sample_ctrl_regs_if.sv
// app_axi req/ack register access bundle.
// Master drives requests, slave returns one-cycle acks.
interface adc_mc_sample_ctrl_regs_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          rreq;
  logic [AW-1:0] raddr;
  logic          rack;
  logic [DW-1:0] rdata;
  logic          wreq;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wack;

  modport master (
    output rreq, raddr, wreq, waddr, wdata,
    input  rack, rdata, wack
  );
  modport slave (
    input  rreq, raddr, wreq, waddr, wdata,
    output rack, rdata, wack
  );
endinterface

// File: rtl/adc_mc_sample_ctrl_regs.sv
// ADC multi-channel register bank and control sequencer:
// per-channel config, sticky status, start/trig/update, reset FSM, irq.
module adc_mc_sample_ctrl_regs #(
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_ADDR_WIDTH = 16,
  parameter int NUM_CH           = 4,
  parameter int DRAIN_TIMEOUT    = 65535,
  parameter int FLUSH_CYC        = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  adc_mc_sample_ctrl_regs_if.slave app_axi,
  output logic [64*NUM_CH-1:0]   cfg_start_addr,
  output logic [64*NUM_CH-1:0]   cfg_end_addr,
  output logic [32*NUM_CH-1:0]   cfg_sample_num,
  output logic [32*NUM_CH-1:0]   cfg_pre_sample_num,
  output logic [NUM_CH-1:0]      sample_start,
  output logic [NUM_CH-1:0]      sample_trig,
  output logic [NUM_CH-1:0]      update_config,
  input  logic [NUM_CH-1:0]      sample_busy,
  input  logic [NUM_CH-1:0]      sample_done,
  input  logic [NUM_CH-1:0]      sample_err,
  input  logic [NUM_CH-1:0]      move_busy,
  input  logic [NUM_CH-1:0]      move_done,
  input  logic [NUM_CH-1:0]      move_err,
  input  logic [64*NUM_CH-1:0]   move_addr,
  input  logic [64*NUM_CH-1:0]   rec_trig_addr,
  input  logic [64*NUM_CH-1:0]   rec_start_addr,
  input  logic [64*NUM_CH-1:0]   rec_end_addr,
  output logic [NUM_CH-1:0]      move_en,
  output logic [NUM_CH-1:0]      sample_reset_n,
  output logic [NUM_CH-1:0]      move_reset_n,
  output logic [NUM_CH-1:0]      data_buffer_reset_n,
  output logic [NUM_CH-1:0]      pkt_info_clr,
  output logic                   irq
);
  localparam logic [31:0] ID = 32'hF7DEC7A6;
  localparam int CMAX =
    (DRAIN_TIMEOUT > FLUSH_CYC) ? DRAIN_TIMEOUT : FLUSH_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] FL_LAST = CW'(FLUSH_CYC - 1);
  localparam logic [15:0] CHM = 16'((32'd1 << NUM_CH) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE, S_ASSERT, S_DRAIN, S_FLUSH
  } rst_st_t;

  logic [S_AXI_ADDR_WIDTH-1:0] wa, ra;
  logic [S_AXI_DATA_WIDTH-1:0] wd, rd_val;
  logic [7:0] wo, ro;
  logic wg;
  logic [NUM_CH-1:0] wr_start, wr_reset, wr_update;
  logic [NUM_CH-1:0] pend_v, busy_v, done_v, err_v;
  logic [31:0] irq_en, irq_pend;
  logic [31:0] ch_rd [NUM_CH];

  assign wa = app_axi.waddr;
  assign ra = app_axi.raddr;
  assign wd = app_axi.wdata;
  assign wo = wa[7:0];
  assign ro = ra[7:0];
  assign wg = app_axi.wreq && (wa[15:8] == 8'h00);
  assign wr_start  = (wg && wo == 8'h08) ? wd[NUM_CH-1:0] : '0;
  assign wr_reset  = (wg && wo == 8'h0C) ? wd[NUM_CH-1:0] : '0;
  assign wr_update = (wg && wo == 8'h10) ? wd[NUM_CH-1:0] : '0;
  assign irq_pend  = {16'(err_v), 16'(done_v)} & irq_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      app_axi.rack  <= 1'b0;
      app_axi.wack  <= 1'b0;
      app_axi.rdata <= '0;
      irq_en        <= '0;
      irq           <= 1'b0;
    end else begin
      app_axi.rack <= app_axi.rreq;
      app_axi.wack <= app_axi.wreq;
      if (app_axi.rreq) app_axi.rdata <= rd_val;
      if (wg && wo == 8'h14) irq_en <= wd & {CHM, CHM};
      irq <= |irq_pend;
    end
  end

  always_comb begin
    rd_val = '0;
    if (ra[15:8] == 8'h00) begin
      case (ro)
        8'h00:   rd_val = ID;
        8'h04:   rd_val = 32'(NUM_CH);
        8'h08:   rd_val = 32'(pend_v);
        8'h0C:   rd_val = 32'(busy_v);
        8'h14:   rd_val = irq_en;
        8'h18:   rd_val = irq_pend;
        default: rd_val = '0;
      endcase
    end else if (ra[15:12] == 4'h1) begin
      for (int i = 0; i < NUM_CH; i++)
        if (ra[11:8] == 4'(i)) rd_val = ch_rd[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [3:0] CH = 4'(g);
    rst_st_t st;
    logic [CW-1:0] cnt;
    logic [63:0] sa, ea;
    logic [31:0] sn, pn, clr, rd;
    logic tv, tm, tp, trig_q, ss_q, pend, upd_q, upd_o;
    logic md, me, sd, se, drop, tmo;
    logic men, srn, mrn, dbrn, pic;
    logic we, to_ev;

    assign we = app_axi.wreq && wa[15:12] == 4'h1
             && wa[11:8] == CH && srn;
    assign clr = (we && wo == 8'h1C) ? wd : '0;
    assign to_ev = st == S_DRAIN && move_busy[g] && cnt == TO_LAST;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sa <= '0; ea <= '0; sn <= '0; pn <= '0;
        tv <= 1'b0; tm <= 1'b0; tp <= 1'b0; trig_q <= 1'b0;
        ss_q <= 1'b0; pend <= 1'b0;
        md <= 1'b0; me <= 1'b0; sd <= 1'b0; se <= 1'b0; drop <= 1'b0;
      end else if (!srn) begin
        sa <= '0; ea <= '0; sn <= '0; pn <= '0;
        tv <= 1'b0; tm <= 1'b0; tp <= 1'b0; trig_q <= 1'b0;
        ss_q <= 1'b0; pend <= 1'b0;
        md <= 1'b0; me <= 1'b0; sd <= 1'b0; se <= 1'b0; drop <= 1'b0;
      end else begin
        if (we) begin
          case (wo)
            8'h00: sa[31:0]  <= wd;
            8'h04: sa[63:32] <= wd;
            8'h08: ea[31:0]  <= wd;
            8'h0C: ea[63:32] <= wd;
            8'h10: sn        <= wd;
            8'h14: pn        <= wd;
            8'h18: begin
              tm <= wd[1];
              tv <= wd[0] & ~wd[1];
            end
            default: ;
          endcase
        end
        tp     <= we && wo == 8'h18 && wd[1] && wd[0];
        trig_q <= tm ? tp : tv;
        pend   <= wr_start[g];
        // a start that finds the sampler already busy is dropped
        if (pend && !sample_busy[g]) ss_q <= 1'b1;
        else if (sample_busy[g])     ss_q <= 1'b0;
        md   <= (md & ~clr[0])  | move_done[g];
        me   <= (me & ~clr[1])  | move_err[g];
        sd   <= (sd & ~clr[16]) | sample_done[g];
        se   <= (se & ~clr[17]) | sample_err[g];
        drop <= (drop & ~clr[19]) | (pend & sample_busy[g]);
      end
    end

    // timeout flag reports the reset outcome, so it survives the flush
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) tmo <= 1'b0;
      else       tmo <= (tmo & ~clr[20]) | to_ev;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        upd_q <= 1'b0;
        upd_o <= 1'b0;
      end else begin
        upd_q <= wr_update[g];
        upd_o <= upd_q;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        st <= S_IDLE; cnt <= '0;
        men <= 1'b0; srn <= 1'b0; mrn <= 1'b0;
        dbrn <= 1'b0; pic <= 1'b1;
      end else begin
        unique case (st)
          S_IDLE: begin
            mrn <= 1'b1; dbrn <= 1'b1;
            if (wr_reset[g]) begin
              st <= S_ASSERT;
              men <= 1'b0; srn <= 1'b0; pic <= 1'b1;
            end else begin
              men <= 1'b1; srn <= 1'b1; pic <= 1'b0;
            end
          end
          S_ASSERT: begin
            st <= S_DRAIN; cnt <= '0;
          end
          S_DRAIN: begin
            if (!move_busy[g] || cnt == TO_LAST) begin
              st <= S_FLUSH; cnt <= '0;
              mrn <= 1'b0; dbrn <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_FLUSH: begin
            if (cnt == FL_LAST) begin
              st <= S_IDLE;
              men <= 1'b1; srn <= 1'b1; pic <= 1'b0;
              mrn <= 1'b1; dbrn <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        endcase
      end
    end

    always_comb begin
      rd = '0;
      case (ro)
        8'h00: rd = sa[31:0];
        8'h04: rd = sa[63:32];
        8'h08: rd = ea[31:0];
        8'h0C: rd = ea[63:32];
        8'h10: rd = sn;
        8'h14: rd = pn;
        8'h18: rd = {30'd0, tm, tv};
        8'h1C: rd = {11'd0, tmo, drop, sample_busy[g], se, sd,
                     13'd0, move_busy[g], me, md};
        8'h20: rd = rec_start_addr[64*g +: 32];
        8'h24: rd = rec_start_addr[64*g+32 +: 32];
        8'h28: rd = rec_end_addr[64*g +: 32];
        8'h2C: rd = rec_end_addr[64*g+32 +: 32];
        8'h30: rd = rec_trig_addr[64*g +: 32];
        8'h34: rd = rec_trig_addr[64*g+32 +: 32];
        8'h38: rd = move_addr[64*g +: 32];
        8'h3C: rd = move_addr[64*g+32 +: 32];
        default: rd = '0;
      endcase
    end

    assign ch_rd[g] = rd;
    assign cfg_start_addr[64*g +: 64]     = sa;
    assign cfg_end_addr[64*g +: 64]       = ea;
    assign cfg_sample_num[32*g +: 32]     = sn;
    assign cfg_pre_sample_num[32*g +: 32] = pn;
    assign sample_start[g]        = ss_q;
    assign sample_trig[g]         = trig_q;
    assign update_config[g]       = upd_o;
    assign move_en[g]             = men;
    assign sample_reset_n[g]      = srn;
    assign move_reset_n[g]        = mrn;
    assign data_buffer_reset_n[g] = dbrn;
    assign pkt_info_clr[g]        = pic;
    assign pend_v[g] = pend;
    assign busy_v[g] = st != S_IDLE;
    assign done_v[g] = md | sd;
    assign err_v[g]  = me | se;
  end
endmodule

// File: tb/tb_adc_mc_sample_ctrl_regs.sv
// Bench for adc_mc_sample_ctrl_regs: random cfg traffic vs a shadow
// register model, plus directed start/irq/trig/reset-sequence steps.
module tb_adc_mc_sample_ctrl_regs;
  localparam int NCH = 4;
  localparam int DTO = 16;
  localparam int FLC = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  adc_mc_sample_ctrl_regs_if #(.AW(16), .DW(32)) bus ();

  logic [64*NCH-1:0] cfg_start_addr, cfg_end_addr;
  logic [64*NCH-1:0] move_addr, rec_trig_addr;
  logic [64*NCH-1:0] rec_start_addr, rec_end_addr;
  logic [32*NCH-1:0] cfg_sample_num, cfg_pre_sample_num;
  logic [NCH-1:0] sample_start, sample_trig, update_config;
  logic [NCH-1:0] sample_busy, sample_done, sample_err;
  logic [NCH-1:0] move_busy, move_done, move_err;
  logic [NCH-1:0] move_en, sample_reset_n, move_reset_n;
  logic [NCH-1:0] data_buffer_reset_n, pkt_info_clr;
  logic irq;

  int total = 0;
  int bad = 0;
  logic [63:0] m_sa [NCH];
  logic [63:0] m_ea [NCH];
  logic [31:0] m_sn [NCH];
  logic [31:0] m_pn [NCH];

  adc_mc_sample_ctrl_regs #(
    .S_AXI_DATA_WIDTH(32), .S_AXI_ADDR_WIDTH(16), .NUM_CH(NCH),
    .DRAIN_TIMEOUT(DTO), .FLUSH_CYC(FLC)
  ) dut (
    .clk(clk), .rstn(rstn), .app_axi(bus),
    .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
    .cfg_sample_num(cfg_sample_num),
    .cfg_pre_sample_num(cfg_pre_sample_num),
    .sample_start(sample_start), .sample_trig(sample_trig),
    .update_config(update_config),
    .sample_busy(sample_busy), .sample_done(sample_done),
    .sample_err(sample_err),
    .move_busy(move_busy), .move_done(move_done), .move_err(move_err),
    .move_addr(move_addr), .rec_trig_addr(rec_trig_addr),
    .rec_start_addr(rec_start_addr), .rec_end_addr(rec_end_addr),
    .move_en(move_en), .sample_reset_n(sample_reset_n),
    .move_reset_n(move_reset_n),
    .data_buffer_reset_n(data_buffer_reset_n),
    .pkt_info_clr(pkt_info_clr), .irq(irq)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    bus.wreq = 1'b1; bus.waddr = a; bus.wdata = d;
    step();
    bus.wreq = 1'b0;
  endtask

  task automatic rdchk(input logic [15:0] a, input logic [31:0] exp,
                       input string tag);
    bus.rreq = 1'b1; bus.raddr = a;
    step();
    bus.rreq = 1'b0;
    check({tag, "_rack"}, 64'(bus.rack), 64'd1);
    check(tag, 64'(bus.rdata), 64'(exp));
  endtask

  task automatic mwr(input int c, input int idx, input logic [31:0] d);
    case (idx)
      0: m_sa[c][31:0]  = d;
      1: m_sa[c][63:32] = d;
      2: m_ea[c][31:0]  = d;
      3: m_ea[c][63:32] = d;
      4: m_sn[c]        = d;
      default: m_pn[c]  = d;
    endcase
  endtask

  function automatic logic [31:0] mval(input int c, input int idx);
    case (idx)
      0: return m_sa[c][31:0];
      1: return m_sa[c][63:32];
      2: return m_ea[c][31:0];
      3: return m_ea[c][63:32];
      4: return m_sn[c];
      default: return m_pn[c];
    endcase
  endfunction

  task automatic cmp_cfg(input string tag);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("%s_sa%0d", tag, c),
            cfg_start_addr[64*c +: 64], m_sa[c]);
      check($sformatf("%s_ea%0d", tag, c),
            cfg_end_addr[64*c +: 64], m_ea[c]);
      check($sformatf("%s_sn%0d", tag, c),
            64'(cfg_sample_num[32*c +: 32]), 64'(m_sn[c]));
      check($sformatf("%s_pn%0d", tag, c),
            64'(cfg_pre_sample_num[32*c +: 32]), 64'(m_pn[c]));
    end
  endtask

  initial begin
    int c, idx, lo_s, lo_m, first_m;
    logic [31:0] d;
    logic [15:0] a;
    bus.rreq = 1'b0; bus.wreq = 1'b0;
    bus.raddr = '0; bus.waddr = '0; bus.wdata = '0;
    sample_busy = '0; sample_done = '0; sample_err = '0;
    move_busy = '0; move_done = '0; move_err = '0;
    for (int i = 0; i < 4 * NCH; i++) begin
      move_addr[32*i +: 32]      = $urandom;
      rec_trig_addr[32*i +: 32]  = $urandom;
      rec_start_addr[32*i +: 32] = $urandom;
      rec_end_addr[32*i +: 32]   = $urandom;
    end
    for (int i = 0; i < NCH; i++) begin
      m_sa[i] = '0; m_ea[i] = '0; m_sn[i] = '0; m_pn[i] = '0;
    end

    rstn = 1'b1;
    #2 rstn = 1'b0;
    #20;
    check("rst_rack", 64'(bus.rack), 64'd0);
    check("rst_move_en", 64'(move_en), 64'h0);
    check("rst_srn", 64'(sample_reset_n), 64'h0);
    check("rst_mrn", 64'(move_reset_n), 64'h0);
    check("rst_pic", 64'(pkt_info_clr), 64'hF);
    check("rst_irq", 64'(irq), 64'd0);
    cmp_cfg("rst");
    @(negedge clk) rstn = 1'b1;
    step();
    check("idle_move_en", 64'(move_en), 64'hF);
    check("idle_srn", 64'(sample_reset_n), 64'hF);
    check("idle_dbrn", 64'(data_buffer_reset_n), 64'hF);
    check("idle_pic", 64'(pkt_info_clr), 64'h0);

    rdchk(16'h0000, 32'hF7DEC7A6, "id");
    rdchk(16'h0004, NCH, "num_ch");
    step();
    check("rack_1cyc", 64'(bus.rack), 64'd0);

    for (int i = 0; i < 24; i++) begin
      c = $urandom_range(0, NCH - 1);
      idx = $urandom_range(0, 5);
      d = $urandom;
      a = 16'h1000 + 16'(c * 256) + 16'(idx * 4);
      wr(a, d);
      mwr(c, idx, d);
    end
    cmp_cfg("rnd");
    for (int i = 0; i < 8; i++) begin
      c = $urandom_range(0, NCH - 1);
      idx = $urandom_range(0, 5);
      a = 16'h1000 + 16'(c * 256) + 16'(idx * 4);
      rdchk(a, mval(c, idx), $sformatf("rnd_rd%0d", i));
    end
    wr(16'h1200, 32'h1000); mwr(2, 0, 32'h1000);
    wr(16'h1204, 32'h1);    mwr(2, 1, 32'h1);
    check("ch2_start", cfg_start_addr[191:128], 64'h1_0000_1000);
    wr(16'h1400, 32'hDEAD_BEEF);
    cmp_cfg("ch2");
    rdchk(16'h1400, 32'h0, "ch4_rd");
    rdchk(16'h0020, 32'h0, "unmapped_rd");
    rdchk(16'h1338, move_addr[3*64 +: 32], "mv_addr3");
    rdchk(16'h1024, rec_start_addr[32 +: 32], "rec_start0_hi");

    wr(16'h0008, 32'h5);
    check("start_lat1", 64'(sample_start), 64'h0);
    step();
    check("start_on", 64'(sample_start), 64'h5);
    step();
    check("start_hold", 64'(sample_start), 64'h5);
    sample_busy[0] = 1'b1;
    step();
    check("start_drop0", 64'(sample_start), 64'h4);
    sample_busy[2] = 1'b1;
    step();
    check("start_drop2", 64'(sample_start), 64'h0);
    wr(16'h0008, 32'h4);
    step();
    check("start_busy", 64'(sample_start), 64'h0);
    rdchk(16'h121C, 32'h000C_0000, "st2_dropped");
    rdchk(16'h101C, 32'h0004_0000, "st0_busy");
    wr(16'h121C, 32'h0008_0000);
    rdchk(16'h121C, 32'h0004_0000, "st2_w1c");
    sample_busy = '0;

    wr(16'h0014, 32'h2);
    sample_done[1] = 1'b1;
    step();
    sample_done[1] = 1'b0;
    check("irq_lat", 64'(irq), 64'd0);
    step();
    check("irq_set", 64'(irq), 64'd1);
    rdchk(16'h0018, 32'h2, "irq_pend");
    bus.wreq = 1'b1; bus.waddr = 16'h111C; bus.wdata = 32'h1_0000;
    sample_done[1] = 1'b1;
    step();
    bus.wreq = 1'b0; sample_done[1] = 1'b0;
    step();
    check("irq_setwins", 64'(irq), 64'd1);
    rdchk(16'h111C, 32'h1_0000, "st1_setwins");
    wr(16'h111C, 32'h1_0000);
    step();
    check("irq_clr", 64'(irq), 64'd0);
    wr(16'h0014, 32'h8_0000);
    move_err[3] = 1'b1;
    step();
    move_err[3] = 1'b0;
    step();
    check("irq_err", 64'(irq), 64'd1);
    rdchk(16'h0018, 32'h8_0000, "irq_pend_err");
    rdchk(16'h131C, 32'h2, "st3_merr");
    wr(16'h131C, 32'h2);
    step();
    check("irq_err_clr", 64'(irq), 64'd0);

    wr(16'h0010, 32'hA);
    check("upd_lat1", 64'(update_config), 64'h0);
    step();
    check("upd_pulse", 64'(update_config), 64'hA);
    step();
    check("upd_end", 64'(update_config), 64'h0);

    wr(16'h1018, 32'h1);
    step();
    check("trig_lvl", 64'(sample_trig), 64'h1);
    wr(16'h1018, 32'h0);
    step();
    check("trig_lvl0", 64'(sample_trig), 64'h0);
    wr(16'h1318, 32'h3);
    step();
    check("trig_pulse", 64'(sample_trig), 64'h8);
    step();
    check("trig_pulse_end", 64'(sample_trig), 64'h0);
    rdchk(16'h1318, 32'h2, "trig_rd");

    wr(16'h1010, 32'h55); mwr(0, 4, 32'h55);
    move_busy[0] = 1'b1;
    wr(16'h000C, 32'h1);
    check("rs_pic", 64'(pkt_info_clr[0]), 64'd1);
    check("rs_men", 64'(move_en[0]), 64'd0);
    lo_s = 0; lo_m = 0; first_m = -1;
    for (int i = 0; i < 40; i++) begin
      if (!sample_reset_n[0]) lo_s++;
      if (!move_reset_n[0]) begin
        lo_m++;
        if (first_m < 0) first_m = i;
      end
      if (i == 1)
        check("rs_clr_sn", 64'(cfg_sample_num[31:0]), 64'd0);
      if (i == 10) move_busy[0] = 1'b0;
      step();
    end
    check("rs_srn_low", lo_s, 1 + 10 + FLC);
    check("rs_flush_at", first_m, 1 + 10);
    check("rs_flush_len", lo_m, FLC);
    m_sa[0] = '0; m_ea[0] = '0; m_sn[0] = '0; m_pn[0] = '0;
    cmp_cfg("rs");
    rdchk(16'h101C, 32'h0, "rs_no_tmo");
    rdchk(16'h000C, 32'h0, "rs_idle");

    move_busy[1] = 1'b1;
    wr(16'h000C, 32'h2);
    lo_m = 0; first_m = -1;
    for (int i = 0; i < 30; i++) begin
      if (!move_reset_n[1]) begin
        lo_m++;
        if (first_m < 0) first_m = i;
      end
      step();
    end
    check("to_flush_at", first_m, 1 + DTO);
    check("to_flush_len", lo_m, FLC);
    rdchk(16'h111C, 32'h0010_0004, "to_status");

    move_busy[2] = 1'b1;
    wr(16'h000C, 32'h4);
    repeat (DTO + 2) step();
    check("mid_flush", 64'(move_reset_n[2]), 64'd0);
    rstn = 1'b0;
    #1;
    check("ar_mrn", 64'(move_reset_n), 64'h0);
    check("ar_srn", 64'(sample_reset_n), 64'h0);
    check("ar_pic", 64'(pkt_info_clr), 64'hF);
    check("ar_men", 64'(move_en), 64'h0);
    check("ar_cfg", 64'(|{cfg_start_addr, cfg_end_addr,
                          cfg_sample_num, cfg_pre_sample_num}), 64'd0);
    #3 rstn = 1'b1;
    step();
    check("ar_idle", 64'(move_reset_n & sample_reset_n), 64'hF);
    rdchk(16'h000C, 32'h0, "ar_seq_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
